// File: rtl/axis_ft245_device.sv
`default_nettype none
// ============================================================================
//  Module   : axis_ft245_device
//  Brief    : FT245 async-FIFO responder. This is the chip side of the FT245
//             bus. It drives the RXF#/TXE# handshakes, answers RD#/WR#
//             strobes, and bridges both data directions to AXI-stream.
//  Revision : 1.0  initial release
// ============================================================================
module axis_ft245_device #(
  parameter int RX_DEPTH            = 16,
  parameter int TX_DEPTH            = 16,
  parameter int SYNC_STAGES         = 2,
  parameter int RD_ACCESS_CYCLES    = 3,
  parameter int RXF_INACTIVE_CYCLES = 4,
  parameter int TXE_INACTIVE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ft_rd_n,
  input  logic       ft_wr_n,
  input  logic       ft_siwu_n,
  input  logic [7:0] ft_d_in,
  output logic [7:0] ft_d_out,
  output logic       ft_d_oe,
  output logic       ft_rxf_n,
  output logic       ft_txe_n,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       flush_pulse,
  output logic       err_rd,
  output logic       err_wr,
  output logic       err_conflict
);

  localparam int RX_AW  = $clog2(RX_DEPTH);
  localparam int TX_AW  = $clog2(TX_DEPTH);
  localparam int RD_MAX = (RD_ACCESS_CYCLES > RXF_INACTIVE_CYCLES) ?
                          RD_ACCESS_CYCLES : RXF_INACTIVE_CYCLES;
  localparam int RCW    = (RD_MAX > 1) ? $clog2(RD_MAX) : 1;
  localparam int WCW    = (TXE_INACTIVE_CYCLES > 1) ? $clog2(TXE_INACTIVE_CYCLES) : 1;

  localparam logic [RCW-1:0]         c_ACC_LOAD = RCW'(RD_ACCESS_CYCLES - 1);
  localparam logic [RCW-1:0]         c_RXF_LOAD = RCW'(RXF_INACTIVE_CYCLES - 1);
  localparam logic [WCW-1:0]         c_TXE_LOAD = WCW'(TXE_INACTIVE_CYCLES - 1);
  localparam logic [RX_AW:0]         c_RX_FULL  = (RX_AW+1)'(RX_DEPTH);
  localparam logic [TX_AW:0]         c_TX_FULL  = (TX_AW+1)'(TX_DEPTH);
  localparam logic [SYNC_STAGES-1:0] c_VLD_ONE  = SYNC_STAGES'(1);

  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_DRIVE, R_RECOVER} rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_ACTIVE, W_RECOVER} wr_state_t;

  // --------------------------------------------------------------------------
  // Input synchronizers and edge detection. Each stage holds
  // {siwu_n, wr_n, rd_n, d[7:0]}. r_vld marks when the last stage holds a
  // real pin sample instead of the reset preset. A strobe is armed only
  // after a genuine high sample has been seen, so a strobe held low across
  // reset cannot produce a false fall.
  // --------------------------------------------------------------------------
  logic [10:0]            r_sync [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] r_vld;
  logic [2:0]             r_prev;
  logic [2:0]             r_armed;
  logic                   r_live;
  logic [10:0]            w_last;
  logic [2:0]             w_fall;
  logic [1:0]             w_rise;

  assign w_last = r_sync[SYNC_STAGES-1];
  assign w_fall = r_armed & r_prev & ~w_last[10:8];
  assign w_rise = r_armed[1:0] & ~r_prev[1:0] & w_last[9:8];

  // Shift pins through the synchronizer and track the arming state
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '1;
      r_vld   <= '0;
      r_prev  <= '1;
      r_armed <= '0;
      r_live  <= 1'b0;
    end else begin
      r_sync[0] <= {ft_siwu_n, ft_wr_n, ft_rd_n, ft_d_in};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_vld  <= (r_vld << 1) | c_VLD_ONE;
      r_prev <= w_last[10:8];
      if (r_vld[SYNC_STAGES-1]) r_armed <= r_armed | w_last[10:8];
      r_live <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Buffers
  // --------------------------------------------------------------------------
  logic [7:0]       r_rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] r_rx_wp, r_rx_rp;
  logic [RX_AW:0]   r_rx_cnt;
  logic [7:0]       r_tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] r_tx_wp, r_tx_rp;
  logic [TX_AW:0]   r_tx_cnt;
  logic             w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
  logic             w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;

  assign w_rx_full     = (r_rx_cnt == c_RX_FULL);
  assign w_rx_empty    = (r_rx_cnt == '0);
  assign w_tx_full     = (r_tx_cnt == c_TX_FULL);
  assign w_tx_empty    = (r_tx_cnt == '0);
  assign s_axis_tready = ~w_rx_full;
  assign w_rx_push     = s_axis_tvalid & ~w_rx_full;
  assign m_axis_tvalid = ~w_tx_empty;
  assign m_axis_tdata  = r_tx_mem[r_tx_rp];
  assign w_tx_pop      = m_axis_tvalid & m_axis_tready;

  // Buffer storage; the contents need no reset because the counts gate them
  always_ff @(posedge clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wp] <= s_axis_tdata;
    if (w_tx_push) r_tx_mem[r_tx_wp] <= w_last[7:0];
  end

  // Buffer pointers and occupancy counts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
      if (w_rx_push && !w_rx_pop)      r_rx_cnt <= r_rx_cnt + 1'b1;
      else if (!w_rx_push && w_rx_pop) r_rx_cnt <= r_rx_cnt - 1'b1;
      if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
      if (w_tx_push && !w_tx_pop)      r_tx_cnt <= r_tx_cnt + 1'b1;
      else if (!w_tx_push && w_tx_pop) r_tx_cnt <= r_tx_cnt - 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Strobe qualification. A strobe is rejected when both strobes fall
  // together, or when one falls while the other direction is busy.
  // --------------------------------------------------------------------------
  rd_state_t      r_rd_state, w_rd_state_nxt;
  wr_state_t      r_wr_state, w_wr_state_nxt;
  logic [RCW-1:0] r_rd_cnt, w_rd_cnt_nxt;
  logic [WCW-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic           w_rxf_n, w_txe_n;
  logic           w_rd_conf, w_wr_conf, w_rd_accept, w_wr_accept;

  assign w_rxf_n     = ~(r_live && (r_rd_state == R_IDLE) && !w_rx_empty);
  assign w_txe_n     = ~(r_live && (r_wr_state == W_IDLE) && !w_tx_full);
  assign w_rd_conf   = w_fall[0] & (w_fall[1] | (r_wr_state != W_IDLE));
  assign w_wr_conf   = w_fall[1] & (w_fall[0] | (r_rd_state != R_IDLE));
  assign w_rd_accept = w_fall[0] & ~w_rd_conf & ~w_rxf_n;
  assign w_wr_accept = w_fall[1] & ~w_wr_conf & ~w_txe_n;
  assign w_tx_push   = w_wr_accept;

  assign ft_rxf_n = w_rxf_n;
  assign ft_txe_n = w_txe_n;
  assign ft_d_oe  = (r_rd_state == R_DRIVE);
  assign ft_d_out = (r_rd_state == R_DRIVE) ? r_rx_mem[r_rx_rp] : 8'h00;

  // State and counter registers for both handshake FSMs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= R_IDLE;
      r_wr_state <= W_IDLE;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
    end else begin
      r_rd_state <= w_rd_state_nxt;
      r_wr_state <= w_wr_state_nxt;
      r_rd_cnt   <= w_rd_cnt_nxt;
      r_wr_cnt   <= w_wr_cnt_nxt;
    end
  end

  // Read FSM: access delay, drive the head byte, pop on RD# rise, then recover
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_cnt_nxt   = r_rd_cnt;
    w_rx_pop       = 1'b0;
    unique case (r_rd_state)
      R_IDLE: begin
        if (w_rd_accept) begin
          w_rd_state_nxt = R_ACCESS;
          w_rd_cnt_nxt   = c_ACC_LOAD;
        end
      end
      R_ACCESS: begin
        if (w_rise[0]) begin
          w_rx_pop       = 1'b1;
          w_rd_state_nxt = R_RECOVER;
          w_rd_cnt_nxt   = c_RXF_LOAD;
        end else if (r_rd_cnt == '0) begin
          w_rd_state_nxt = R_DRIVE;
        end else begin
          w_rd_cnt_nxt = r_rd_cnt - 1'b1;
        end
      end
      R_DRIVE: begin
        if (w_rise[0]) begin
          w_rx_pop       = 1'b1;
          w_rd_state_nxt = R_RECOVER;
          w_rd_cnt_nxt   = c_RXF_LOAD;
        end
      end
      R_RECOVER: begin
        if (r_rd_cnt == '0) w_rd_state_nxt = R_IDLE;
        else                w_rd_cnt_nxt   = r_rd_cnt - 1'b1;
      end
      default: w_rd_state_nxt = R_IDLE;
    endcase
  end

  // Write FSM: byte is captured on the accepted WR# fall, then wait for rise and recover
  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_wr_cnt_nxt   = r_wr_cnt;
    unique case (r_wr_state)
      W_IDLE: begin
        if (w_wr_accept) w_wr_state_nxt = W_ACTIVE;
      end
      W_ACTIVE: begin
        if (w_rise[1]) begin
          w_wr_state_nxt = W_RECOVER;
          w_wr_cnt_nxt   = c_TXE_LOAD;
        end
      end
      W_RECOVER: begin
        if (r_wr_cnt == '0) w_wr_state_nxt = W_IDLE;
        else                w_wr_cnt_nxt   = r_wr_cnt - 1'b1;
      end
      default: w_wr_state_nxt = W_IDLE;
    endcase
  end

  // Sticky protocol-error flags and the send-immediate pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      err_rd       <= 1'b0;
      err_wr       <= 1'b0;
      err_conflict <= 1'b0;
      flush_pulse  <= 1'b0;
    end else begin
      if (w_rd_conf || w_wr_conf)               err_conflict <= 1'b1;
      if (w_fall[0] && !w_rd_conf && w_rxf_n)   err_rd       <= 1'b1;
      if (w_fall[1] && !w_wr_conf && w_txe_n)   err_wr       <= 1'b1;
      flush_pulse <= w_fall[2];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_ft245_device.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_ft245_device
//  Brief    : Directed self-checking bench for axis_ft245_device. The bench
//             emulates the bus initiator at the pin level.
//  Revision : 1.0  initial release
// ============================================================================
module tb_axis_ft245_device;

  logic       clk = 1'b0;
  logic       rst;
  logic       ft_rd_n, ft_wr_n, ft_siwu_n;
  logic [7:0] ft_d_in;
  logic [7:0] ft_d_out;
  logic       ft_d_oe, ft_rxf_n, ft_txe_n;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid, s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tready;
  logic       flush_pulse, err_rd, err_wr, err_conflict;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axis_ft245_device dut (
    .clk           (clk),
    .rst           (rst),
    .ft_rd_n       (ft_rd_n),
    .ft_wr_n       (ft_wr_n),
    .ft_siwu_n     (ft_siwu_n),
    .ft_d_in       (ft_d_in),
    .ft_d_out      (ft_d_out),
    .ft_d_oe       (ft_d_oe),
    .ft_rxf_n      (ft_rxf_n),
    .ft_txe_n      (ft_txe_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .flush_pulse   (flush_pulse),
    .err_rd        (err_rd),
    .err_wr        (err_wr),
    .err_conflict  (err_conflict)
  );

  // Advance n clock edges; inputs are driven and outputs sampled 1 ns after the edge
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ft_rd_n = 1'b1; ft_wr_n = 1'b1; ft_siwu_n = 1'b1; ft_d_in = 8'h00;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; m_axis_tready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(4);
  endtask

  task automatic push_rx(input logic [7:0] d);
    s_axis_tdata = d; s_axis_tvalid = 1'b1;
    tick(1);
    s_axis_tvalid = 1'b0;
  endtask

  // Pin-level read cycle: wait RXF#, pulse RD# low, capture the driven byte
  task automatic read_byte(output logic [7:0] data, output bit ok);
    int n;
    n = 0;
    ok = 1'b1;
    data = 8'h00;
    while (ft_rxf_n !== 1'b0 && n < 40) begin tick(1); n++; end
    if (ft_rxf_n !== 1'b0) ok = 1'b0;
    ft_rd_n = 1'b0;
    n = 0;
    while (ft_d_oe !== 1'b1 && n < 20) begin tick(1); n++; end
    if (ft_d_oe !== 1'b1) ok = 1'b0;
    data = ft_d_out;
    tick(6);
    ft_rd_n = 1'b1;
    tick(8);
  endtask

  // Pin-level write cycle, issued regardless of TXE#
  task automatic write_byte(input logic [7:0] d);
    ft_d_in = d;
    tick(1);
    ft_wr_n = 1'b0;
    tick(10);
    ft_wr_n = 1'b1;
    tick(8);
  endtask

  task automatic test_reset();
    rst = 1'b1; ft_rd_n = 1'b1; ft_wr_n = 1'b1; ft_siwu_n = 1'b1; ft_d_in = 8'h00;
    s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00; m_axis_tready = 1'b0;
    tick(2);
    checks++;
    if ({ft_d_out, ft_d_oe, ft_rxf_n, ft_txe_n} !== {8'h00, 1'b0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL reset_bus: got d_out=%h oe=%b rxf_n=%b txe_n=%b, want 00 0 1 1",
               ft_d_out, ft_d_oe, ft_rxf_n, ft_txe_n);
    end
    checks++;
    if ({m_axis_tvalid, flush_pulse, err_rd, err_wr, err_conflict} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags: got tvalid/flush/errs=%b want 00000",
               {m_axis_tvalid, flush_pulse, err_rd, err_wr, err_conflict});
    end
    rst = 1'b0;
    tick(4);
    checks++;
    if (ft_txe_n !== 1'b0 || s_axis_tready !== 1'b1 || ft_rxf_n !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got txe_n=%b tready=%b rxf_n=%b want 0 1 1",
               ft_txe_n, s_axis_tready, ft_rxf_n);
    end
  endtask

  task automatic test_read_timing();
    logic [7:0] d;
    bit ok;
    do_reset();
    push_rx(8'hA5);
    push_rx(8'h3C);
    tick(1);
    checks++;
    if (ft_rxf_n !== 1'b0) begin errors++; $display("FAIL rd_avail: got rxf_n=%b want 0", ft_rxf_n); end
    ft_rd_n = 1'b0;
    tick(2);
    checks++;
    if (ft_rxf_n !== 1'b0) begin errors++; $display("FAIL rd_rxf_edge2: got %b want 0", ft_rxf_n); end
    tick(1);
    checks++;
    if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL rd_rxf_edge3: got %b want 1", ft_rxf_n); end
    tick(2);
    checks++;
    if (ft_d_oe !== 1'b0) begin errors++; $display("FAIL rd_oe_edge5: got %b want 0", ft_d_oe); end
    tick(1);
    checks++;
    if (ft_d_oe !== 1'b1 || ft_d_out !== 8'hA5) begin
      errors++;
      $display("FAIL rd_drive_edge6: got oe=%b d=%h want 1 a5", ft_d_oe, ft_d_out);
    end
    tick(6);
    ft_rd_n = 1'b1;
    tick(2);
    checks++;
    if (ft_d_oe !== 1'b1) begin errors++; $display("FAIL rd_hold_after_rise: got oe=%b want 1", ft_d_oe); end
    tick(1);
    checks++;
    if (ft_d_oe !== 1'b0) begin errors++; $display("FAIL rd_release: got oe=%b want 0", ft_d_oe); end
    tick(3);
    checks++;
    if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL rd_recover_hold: got rxf_n=%b want 1", ft_rxf_n); end
    tick(1);
    checks++;
    if (ft_rxf_n !== 1'b0) begin errors++; $display("FAIL rd_recover_end: got rxf_n=%b want 0", ft_rxf_n); end
    read_byte(d, ok);
    checks++;
    if (!ok || d !== 8'h3C) begin errors++; $display("FAIL rd_second: got ok=%0d d=%h want 1 3c", ok, d); end
    tick(10);
    checks++;
    if (ft_rxf_n !== 1'b1 || err_rd !== 1'b0) begin
      errors++;
      $display("FAIL rd_empty: got rxf_n=%b err_rd=%b want 1 0", ft_rxf_n, err_rd);
    end
  endtask

  task automatic test_write_full();
    do_reset();
    ft_d_in = 8'h00;
    tick(1);
    ft_wr_n = 1'b0;
    tick(2);
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL wr_early: got tvalid=%b want 0", m_axis_tvalid); end
    tick(1);
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'h00 || ft_txe_n !== 1'b1) begin
      errors++;
      $display("FAIL wr_push: got tvalid=%b d=%h txe_n=%b want 1 00 1", m_axis_tvalid, m_axis_tdata, ft_txe_n);
    end
    tick(7);
    ft_wr_n = 1'b1;
    tick(8);
    for (int i = 1; i < 16; i++) begin
      checks++;
      if (ft_txe_n !== 1'b0) begin errors++; $display("FAIL wr_space_%0d: got txe_n=%b want 0", i, ft_txe_n); end
      write_byte(8'(i));
    end
    checks++;
    if (ft_txe_n !== 1'b1 || err_wr !== 1'b0) begin
      errors++;
      $display("FAIL wr_full: got txe_n=%b err_wr=%b want 1 0", ft_txe_n, err_wr);
    end
    write_byte(8'hEE);
    checks++;
    if (err_wr !== 1'b1) begin errors++; $display("FAIL wr_overflow: got err_wr=%b want 1", err_wr); end
    m_axis_tready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 8'(i)) begin
        errors++;
        $display("FAIL wr_drain_%0d: got tvalid=%b d=%h want 1 %h", i, m_axis_tvalid, m_axis_tdata, 8'(i));
      end
      tick(1);
    end
    checks++;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL wr_drained: got tvalid=%b want 0", m_axis_tvalid); end
    m_axis_tready = 1'b0;
  endtask

  task automatic test_rx_full();
    logic [7:0] d;
    bit ok;
    do_reset();
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_axis_tdata = 8'h10 + 8'(i);
      tick(1);
    end
    s_axis_tdata = 8'h20;
    checks++;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rx_full: got tready=%b want 0", s_axis_tready); end
    read_byte(d, ok);
    checks++;
    if (!ok || d !== 8'h10) begin errors++; $display("FAIL rx_full_read: got ok=%0d d=%h want 1 10", ok, d); end
    checks++;
    if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rx_refill: got tready=%b want 0", s_axis_tready); end
    s_axis_tvalid = 1'b0;
    for (int i = 1; i < 17; i++) begin
      read_byte(d, ok);
      checks++;
      if (!ok || d !== 8'h10 + 8'(i)) begin
        errors++;
        $display("FAIL rx_order_%0d: got ok=%0d d=%h want 1 %h", i, ok, d, 8'h10 + 8'(i));
      end
    end
    tick(4);
    checks++;
    if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL rx_drained: got rxf_n=%b want 1", ft_rxf_n); end
  endtask

  task automatic test_conflict();
    logic [7:0] d;
    bit ok;
    do_reset();
    push_rx(8'h77);
    ft_d_in = 8'h55;
    tick(1);
    ft_rd_n = 1'b0;
    ft_wr_n = 1'b0;
    tick(4);
    checks++;
    if (err_conflict !== 1'b1 || ft_d_oe !== 1'b0 || m_axis_tvalid !== 1'b0) begin
      errors++;
      $display("FAIL conflict: got errc=%b oe=%b tvalid=%b want 1 0 0", err_conflict, ft_d_oe, m_axis_tvalid);
    end
    tick(10);
    checks++;
    if (ft_d_oe !== 1'b0 || ft_rxf_n !== 1'b0) begin
      errors++;
      $display("FAIL conflict_idle: got oe=%b rxf_n=%b want 0 0", ft_d_oe, ft_rxf_n);
    end
    ft_rd_n = 1'b1;
    ft_wr_n = 1'b1;
    tick(8);
    checks++;
    if (err_rd !== 1'b0 || err_wr !== 1'b0) begin
      errors++;
      $display("FAIL conflict_other_errs: got err_rd=%b err_wr=%b want 0 0", err_rd, err_wr);
    end
    read_byte(d, ok);
    checks++;
    if (!ok || d !== 8'h77) begin errors++; $display("FAIL conflict_no_pop: got ok=%0d d=%h want 1 77", ok, d); end
  endtask

  task automatic test_reset_mid_drive();
    logic [7:0] d;
    bit ok;
    int n;
    do_reset();
    push_rx(8'h99);
    tick(1);
    ft_rd_n = 1'b0;
    n = 0;
    while (ft_d_oe !== 1'b1 && n < 20) begin tick(1); n++; end
    checks++;
    if (ft_d_oe !== 1'b1 || ft_d_out !== 8'h99) begin
      errors++;
      $display("FAIL mid_drive_reach: got oe=%b d=%h want 1 99", ft_d_oe, ft_d_out);
    end
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
    checks++;
    if (ft_d_oe !== 1'b0 || ft_rxf_n !== 1'b1) begin
      errors++;
      $display("FAIL mid_drive_abort: got oe=%b rxf_n=%b want 0 1", ft_d_oe, ft_rxf_n);
    end
    push_rx(8'h42);
    tick(10);
    checks++;
    if (ft_rxf_n !== 1'b0 || ft_d_oe !== 1'b0 || err_rd !== 1'b0) begin
      errors++;
      $display("FAIL held_low_ignored: got rxf_n=%b oe=%b err_rd=%b want 0 0 0", ft_rxf_n, ft_d_oe, err_rd);
    end
    ft_rd_n = 1'b1;
    tick(6);
    checks++;
    if (ft_d_oe !== 1'b0 || ft_rxf_n !== 1'b0) begin
      errors++;
      $display("FAIL held_low_release: got oe=%b rxf_n=%b want 0 0", ft_d_oe, ft_rxf_n);
    end
    read_byte(d, ok);
    checks++;
    if (!ok || d !== 8'h42) begin errors++; $display("FAIL mid_drive_discard: got ok=%0d d=%h want 1 42", ok, d); end
  endtask

  task automatic test_err_rd();
    do_reset();
    ft_rd_n = 1'b0;
    tick(5);
    checks++;
    if (err_rd !== 1'b1 || ft_d_oe !== 1'b0 || ft_rxf_n !== 1'b1) begin
      errors++;
      $display("FAIL err_rd_empty: got err_rd=%b oe=%b rxf_n=%b want 1 0 1", err_rd, ft_d_oe, ft_rxf_n);
    end
    ft_rd_n = 1'b1;
    tick(4);
  endtask

  task automatic test_siwu();
    int pulses;
    do_reset();
    push_rx(8'h31);
    tick(1);
    pulses = 0;
    ft_siwu_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (flush_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1) begin errors++; $display("FAIL siwu_pulse: got %0d pulses want 1", pulses); end
    checks++;
    if (ft_rxf_n !== 1'b0 || ft_txe_n !== 1'b0) begin
      errors++;
      $display("FAIL siwu_no_effect: got rxf_n=%b txe_n=%b want 0 0", ft_rxf_n, ft_txe_n);
    end
    ft_siwu_n = 1'b1;
    tick(4);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [4];
    logic [7:0] d;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp[i] = 8'($urandom_range(0, 255));
      push_rx(exp[i]);
    end
    for (int i = 0; i < 4; i++) begin
      read_byte(d, ok);
      checks++;
      if (!ok || d !== exp[i]) begin
        errors++;
        $display("FAIL b2b_%0d: got ok=%0d d=%h want 1 %h", i, ok, d, exp[i]);
      end
    end
    checks++;
    if ({err_rd, err_wr, err_conflict} !== 3'b000) begin
      errors++;
      $display("FAIL b2b_errs: got %b want 000", {err_rd, err_wr, err_conflict});
    end
  endtask

  initial begin
    test_reset();
    test_read_timing();
    test_write_full();
    test_rx_full();
    test_conflict();
    test_reset_mid_drive();
    test_err_rd();
    test_siwu();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
